// File: rtl/inflation_pkg.sv
// -----------------------------------------------------------------------------
// inflation_pkg
//   Types and derivations shared by the map-inflation blocks (scheduler, weight
//   loader, row accumulator).
//   - sched_state_t  : scheduler FSM states
//   - ceil_div       : integer ceiling division used for beat-count derivations
//   - num_w_words    : AXI-Stream beats needed to carry one KxK weight kernel
//   - num_transfers  : AXI-Stream beats needed to carry one K-pixel input row
// -----------------------------------------------------------------------------
package inflation_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } sched_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int num_w_words(input int kernel_size, input int data_width,
                                     input int bus_width);
    return ceil_div(kernel_size * kernel_size * data_width, bus_width);
  endfunction

  function automatic int num_transfers(input int kernel_size, input int data_width,
                                       input int bus_width);
    return ceil_div(kernel_size * data_width, bus_width);
  endfunction

endpackage

// File: rtl/inflation_stream_scheduler_if.sv
// -----------------------------------------------------------------------------
// inflation_stream_scheduler_if
//   One AXI-Stream link (tdata / tvalid / tready) between the scheduler and its
//   neighbours.
//   Parameter: BUS_WIDTH - tdata width.
//   Modports : master drives tdata/tvalid and observes tready,
//              slave  observes tdata/tvalid and drives tready.
//
//   Handshake: a beat transfers on a rising clk edge where tvalid && tready are
//   both high. Once raised, the master holds tvalid and tdata stable until the
//   beat transfers; tready may change freely and never depends on a registered
//   copy of tvalid.
// -----------------------------------------------------------------------------
interface inflation_stream_scheduler_if #(
  parameter int BUS_WIDTH = 32
);
  logic [BUS_WIDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_beat_counter.sv
// -----------------------------------------------------------------------------
// axis_beat_counter
//   Counts handshake beats. clr has priority over inc.
//   Ports: clk, rstn (sync, active-low), clr, inc, cnt[WIDTH-1:0].
// -----------------------------------------------------------------------------
module axis_beat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/inflation_stream_scheduler.sv
// -----------------------------------------------------------------------------
// inflation_stream_scheduler
//   Sequences one map-inflation job over a single DMA AXI-Stream input: the
//   first NUM_W_WORDS beats go to the weight loader, the next
//   num_rows*NUM_TRANSFERS beats go to the row accumulator. The block then waits
//   for the accumulator to emit num_rows rows, flags the last one and pulses
//   done. Stream routing is purely combinational (zero latency).
//
//   Optional feature macro: STALL_TIMEOUT_EN
//     defined   : stall watchdog; TIMEOUT_CYCLES cycles without any w/a/row
//                 handshake sets sticky timeout and forces the job to DONE.
//     undefined : no watchdog, timeout tied low.
//
//   Ports:
//     clk, rstn          clock, synchronous active-low reset
//     start, num_rows    job start pulse (ignored while busy), row count
//     busy, done         job in progress, one-cycle completion pulse
//     timeout            sticky stall flag, cleared by the next accepted start
//     s_axis (slave)     DMA MM2S stream in
//     w_axis (master)    to weight loader
//     a_axis (master)    to row accumulator slave port
//     acc_enable         accumulator enable (low clears the accumulator)
//     row_tvalid/tready  snooped accumulator output handshake
//     row_tlast          marks the final row of the job
//     dbg_state          current FSM state
// -----------------------------------------------------------------------------
module inflation_stream_scheduler
  import inflation_pkg::*;
#(
  parameter int KERNEL_SIZE    = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int ROWS_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ROWS_WIDTH-1:0] num_rows,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  inflation_stream_scheduler_if.slave  s_axis,
  inflation_stream_scheduler_if.master w_axis,
  inflation_stream_scheduler_if.master a_axis,
  output logic                  acc_enable,
  input  logic                  row_tvalid,
  input  logic                  row_tready,
  output logic                  row_tlast,
  output sched_state_t          dbg_state
);
  localparam int NUM_W_WORDS   = num_w_words(KERNEL_SIZE, DATA_WIDTH, BUS_WIDTH);
  localparam int NUM_TRANSFERS = num_transfers(KERNEL_SIZE, DATA_WIDTH, BUS_WIDTH);
  localparam int W_CNT_W       = $clog2(NUM_W_WORDS + 1);
  // One spare bit so rows_q*NUM_TRANSFERS (and in_words+1) never truncate.
  localparam int IN_W          = ROWS_WIDTH + $clog2(NUM_TRANSFERS) + 1;

  sched_state_t          state_q, state_d;
  logic [ROWS_WIDTH-1:0] rows_q, rows_d;
  logic                  acc_enable_q, acc_enable_d;

  logic                  cnt_clr;
  logic                  w_hs, a_hs, row_hs;
  logic [W_CNT_W-1:0]    w_cnt;
  logic [IN_W-1:0]       in_words;
  logic [IN_W-1:0]       in_target;
  logic [ROWS_WIDTH-1:0] rows_out;
  logic [ROWS_WIDTH-1:0] rows_out_next;
  logic                  wd_expire;

  // ---------------------------------------------------------------------------
  // Stream routing
  // ---------------------------------------------------------------------------
  assign w_axis.tdata  = s_axis.tdata;
  assign a_axis.tdata  = s_axis.tdata;
  assign w_axis.tvalid = (state_q == LOAD_W) && s_axis.tvalid;
  assign a_axis.tvalid = (state_q == STREAM) && s_axis.tvalid;

  always_comb begin
    s_axis.tready = 1'b0;
    case (state_q)
      LOAD_W:  s_axis.tready = w_axis.tready;
      STREAM:  s_axis.tready = a_axis.tready;
      default: s_axis.tready = 1'b0;
    endcase
  end

  assign w_hs   = (state_q == LOAD_W) && s_axis.tvalid && w_axis.tready;
  assign a_hs   = (state_q == STREAM) && s_axis.tvalid && a_axis.tready;
  assign row_hs = ((state_q == STREAM) || (state_q == DRAIN)) && row_tvalid && row_tready;

  // ---------------------------------------------------------------------------
  // Beat counters, all cleared when a job is accepted
  // ---------------------------------------------------------------------------
  axis_beat_counter #(.WIDTH(W_CNT_W)) u_w_cnt (
    .clk (clk), .rstn (rstn), .clr (cnt_clr), .inc (w_hs), .cnt (w_cnt)
  );

  axis_beat_counter #(.WIDTH(IN_W)) u_in_cnt (
    .clk (clk), .rstn (rstn), .clr (cnt_clr), .inc (a_hs), .cnt (in_words)
  );

  axis_beat_counter #(.WIDTH(ROWS_WIDTH)) u_row_cnt (
    .clk (clk), .rstn (rstn), .clr (cnt_clr), .inc (row_hs), .cnt (rows_out)
  );

  assign in_target     = IN_W'(rows_q) * IN_W'(NUM_TRANSFERS);
  // Including this cycle's row beat lets DONE follow the last row by one cycle.
  assign rows_out_next = rows_out + ROWS_WIDTH'(row_hs);

  // ---------------------------------------------------------------------------
  // Stall watchdog
  // ---------------------------------------------------------------------------
`ifdef STALL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            wd_active;

  assign wd_active = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == DRAIN);

  always_comb begin
    wd_d      = '0;
    wd_expire = 1'b0;
    if (wd_active && !(w_hs || a_hs || row_hs)) begin
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        wd_expire = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if ((state_q == IDLE) && start) begin
      timeout_d = 1'b0;
    end else if (wd_expire) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Job FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    acc_enable_d = acc_enable_q;
    cnt_clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          rows_d  = num_rows;
          state_d = (num_rows != '0) ? LOAD_W : DONE;
        end
      end
      LOAD_W: begin
        if (w_hs && (w_cnt == W_CNT_W'(NUM_W_WORDS - 1))) begin
          state_d      = STREAM;
          acc_enable_d = 1'b1;
        end
      end
      STREAM: begin
        if (a_hs && ((in_words + IN_W'(1)) == in_target)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rows_out_next == rows_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        acc_enable_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wd_expire) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      rows_q       <= '0;
      acc_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      acc_enable_q <= acc_enable_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign acc_enable = acc_enable_q;
  assign row_tlast  = row_tvalid && (rows_out == (rows_q - ROWS_WIDTH'(1)));
  assign dbg_state  = state_q;
endmodule
